// File: rtl/pipeline_ctrl_unit_pkg.sv
// Shared types for the pipeline sequencer.
// States plus the per-register stall/flush bundle.
package pipeline_ctrl_unit_pkg;

  typedef enum logic [1:0] {
    PC_RUN,
    PC_DMEM_WAIT,
    PC_FAULT
  } pipe_ctrl_state_e;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic if_id_flush;
    logic id_ex_stall;
    logic id_ex_flush;
    logic ex_mem_stall;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_NONE = '0;

  localparam pipe_ctrl_t CTRL_MEM_STALL = '{
    pc_stall:     1'b1,
    if_id_stall:  1'b1,
    if_id_flush:  1'b0,
    id_ex_stall:  1'b1,
    id_ex_flush:  1'b0,
    ex_mem_stall: 1'b1,
    mem_wb_flush: 1'b1
  };

  localparam pipe_ctrl_t CTRL_REDIRECT = '{
    pc_stall:     1'b0,
    if_id_stall:  1'b0,
    if_id_flush:  1'b1,
    id_ex_stall:  1'b0,
    id_ex_flush:  1'b1,
    ex_mem_stall: 1'b0,
    mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_LOAD_USE = '{
    pc_stall:     1'b1,
    if_id_stall:  1'b1,
    if_id_flush:  1'b0,
    id_ex_stall:  1'b0,
    id_ex_flush:  1'b1,
    ex_mem_stall: 1'b0,
    mem_wb_flush: 1'b0
  };

  localparam pipe_ctrl_t CTRL_IMEM_WAIT = '{
    pc_stall:     1'b1,
    if_id_stall:  1'b0,
    if_id_flush:  1'b1,
    id_ex_stall:  1'b0,
    id_ex_flush:  1'b0,
    ex_mem_stall: 1'b0,
    mem_wb_flush: 1'b0
  };

endpackage

// File: rtl/pipeline_ctrl_unit_load_use_detector.sv
// Load-use hazard compare between the ID operands and the EX load.
// x0 never creates a hazard since it is hardwired to zero.
module pipeline_ctrl_unit_load_use_detector (
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       use_rs1,
  input  logic       use_rs2,
  input  logic [4:0] rd,
  input  logic       mem_read,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1 = use_rs1 && (rs1 == rd);
  assign hit_rs2 = use_rs2 && (rs2 == rd);

  assign load_use = mem_read
                 && (rd != 5'd0)
                 && (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline sequencer: stall/flush enables, data-memory wait FSM,
// sticky timeout fault and saturating stall/flush counters.
module pipeline_ctrl_unit
  import pipeline_ctrl_unit_pkg::*;
#(
  parameter int DMEM_TIMEOUT = 64,
  parameter int CNT_W        = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       id_rs1_i,
  input  logic [4:0]       id_rs2_i,
  input  logic             id_use_rs1_i,
  input  logic             id_use_rs2_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             ex_MemRead_i,
  input  logic             ex_redirect_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic             imem_ready_i,
  output logic             pc_stall_o,
  output logic             if_id_stall_o,
  output logic             if_id_flush_o,
  output logic             id_ex_stall_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_stall_o,
  output logic             mem_wb_flush_o,
  output logic             dmem_req_o,
  output logic             dmem_err_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int WCNT_W = $clog2(DMEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(DMEM_TIMEOUT);

  pipe_ctrl_state_e  state;
  pipe_ctrl_state_e  state_d;
  logic [WCNT_W-1:0] wcnt;
  logic [WCNT_W-1:0] wcnt_d;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  pipe_ctrl_t        ctrl;
  logic              mem_stall;
  logic              req;
  logic              redirect_take;
  logic              load_use;

  pipeline_ctrl_unit_load_use_detector u_lud (
    .rs1      (id_rs1_i),
    .rs2      (id_rs2_i),
    .use_rs1  (id_use_rs1_i),
    .use_rs2  (id_use_rs2_i),
    .rd       (ex_rd_i),
    .mem_read (ex_MemRead_i),
    .load_use (load_use)
  );

  always_comb begin
    state_d       = state;
    wcnt_d        = wcnt;
    mem_stall     = 1'b0;
    req           = 1'b0;
    redirect_take = 1'b0;
    ctrl          = CTRL_NONE;

    unique case (state)
      PC_RUN: begin
        req = mem_access_i;
        if (mem_access_i && !dmem_ready_i) begin
          mem_stall = 1'b1;
          state_d   = PC_DMEM_WAIT;
          wcnt_d    = WCNT_W'(1);
        end
      end
      PC_DMEM_WAIT: begin
        req = 1'b1;
        if (!dmem_ready_i) begin
          mem_stall = 1'b1;
          if (wcnt == WCNT_MAX) begin
            state_d = PC_FAULT;
          end else begin
            wcnt_d = wcnt + 1'b1;
          end
        end else begin
          state_d = PC_RUN;
          wcnt_d  = '0;
        end
      end
      PC_FAULT: begin
        mem_stall = 1'b1;
      end
      default: begin
        state_d = PC_RUN;
        wcnt_d  = '0;
      end
    endcase

    // EX is held during a memory stall, so redirect/load-use replay later
    if (mem_stall) begin
      ctrl = CTRL_MEM_STALL;
    end else if (ex_redirect_i) begin
      ctrl          = CTRL_REDIRECT;
      redirect_take = 1'b1;
    end else if (load_use) begin
      ctrl = CTRL_LOAD_USE;
    end else if (!imem_ready_i) begin
      ctrl = CTRL_IMEM_WAIT;
    end

    if (rst_i) begin
      ctrl          = CTRL_NONE;
      req           = 1'b0;
      redirect_take = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= PC_RUN;
      wcnt      <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state <= state_d;
      wcnt  <= wcnt_d;
      if (ctrl.pc_stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_take && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
    end
  end

  assign pc_stall_o     = ctrl.pc_stall;
  assign if_id_stall_o  = ctrl.if_id_stall;
  assign if_id_flush_o  = ctrl.if_id_flush;
  assign id_ex_stall_o  = ctrl.id_ex_stall;
  assign id_ex_flush_o  = ctrl.id_ex_flush;
  assign ex_mem_stall_o = ctrl.ex_mem_stall;
  assign mem_wb_flush_o = ctrl.mem_wb_flush;
  assign dmem_req_o     = req;
  assign dmem_err_o     = (state == PC_FAULT) && !rst_i;
  assign stall_cnt_o    = stall_cnt;
  assign flush_cnt_o    = flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit (DMEM_TIMEOUT=4, CNT_W=4).
// Outputs are packed as {pc_st,ifid_st,ifid_fl,idex_st,idex_fl,exmem_st,memwb_fl,req,err}.
module tb_pipeline_ctrl_unit;

  localparam int CNT_W = 4;

  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_LU    = 9'b110010000;
  localparam logic [8:0] O_RDIR  = 9'b001010000;
  localparam logic [8:0] O_RDREQ = 9'b001010010;
  localparam logic [8:0] O_MSTL  = 9'b110101110;
  localparam logic [8:0] O_FAULT = 9'b110101101;
  localparam logic [8:0] O_IMEM  = 9'b101000000;
  localparam logic [8:0] O_REQ   = 9'b000000010;

  logic clk = 1'b0;
  logic rst;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2;
  logic ex_mem_read, ex_redirect;
  logic mem_access, dmem_ready, imem_ready;
  logic pc_stall, if_id_stall, if_id_flush;
  logic id_ex_stall, id_ex_flush, ex_mem_stall;
  logic mem_wb_flush, dmem_req, dmem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic [8:0] outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign outs = {pc_stall, if_id_stall, if_id_flush,
                 id_ex_stall, id_ex_flush, ex_mem_stall,
                 mem_wb_flush, dmem_req, dmem_err};

  pipeline_ctrl_unit #(
    .DMEM_TIMEOUT (4),
    .CNT_W        (CNT_W)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .id_rs1_i       (id_rs1),
    .id_rs2_i       (id_rs2),
    .id_use_rs1_i   (id_use_rs1),
    .id_use_rs2_i   (id_use_rs2),
    .ex_rd_i        (ex_rd),
    .ex_MemRead_i   (ex_mem_read),
    .ex_redirect_i  (ex_redirect),
    .mem_access_i   (mem_access),
    .dmem_ready_i   (dmem_ready),
    .imem_ready_i   (imem_ready),
    .pc_stall_o     (pc_stall),
    .if_id_stall_o  (if_id_stall),
    .if_id_flush_o  (if_id_flush),
    .id_ex_stall_o  (id_ex_stall),
    .id_ex_flush_o  (id_ex_flush),
    .ex_mem_stall_o (ex_mem_stall),
    .mem_wb_flush_o (mem_wb_flush),
    .dmem_req_o     (dmem_req),
    .dmem_err_o     (dmem_err),
    .stall_cnt_o    (stall_cnt),
    .flush_cnt_o    (flush_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs1      = 5'd0;
    id_rs2      = 5'd0;
    id_use_rs1  = 1'b0;
    id_use_rs2  = 1'b0;
    ex_rd       = 5'd0;
    ex_mem_read = 1'b0;
    ex_redirect = 1'b0;
    mem_access  = 1'b0;
    dmem_ready  = 1'b0;
    imem_ready  = 1'b1;
  endtask

  task automatic set_hazard();
    ex_mem_read = 1'b1;
    ex_rd       = 5'd5;
    id_rs1      = 5'd5;
    id_use_rs1  = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    set_hazard();
    ex_redirect = 1'b1;
    mem_access  = 1'b1;
    imem_ready  = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL reset_outs got=%b exp=%b", outs, O_NONE);
    end
    tick();
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL reset_hold got=%b exp=%b", outs, O_NONE);
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL reset_idle got=%b exp=%b", outs, O_NONE);
    end
    total++;
    if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin
      bad++;
      $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_hazard();
    #1;
    total++;
    if (outs !== O_LU) begin
      bad++;
      $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL lu_release got=%b exp=%b", outs, O_NONE);
    end
    total++;
    if (stall_cnt !== 4'd1) begin
      bad++;
      $display("FAIL lu_stall_cnt got=%0d exp=1", stall_cnt);
    end
    ex_mem_read = 1'b1;
    ex_rd       = 5'd9;
    id_rs2      = 5'd9;
    id_use_rs2  = 1'b1;
    #1;
    total++;
    if (outs !== O_LU) begin
      bad++;
      $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU);
    end
    id_use_rs2 = 1'b0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL lu_unused got=%b exp=%b", outs, O_NONE);
    end
    ex_mem_read = 1'b0;
    id_use_rs2  = 1'b1;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL lu_noload got=%b exp=%b", outs, O_NONE);
    end
    clear_inputs();
  endtask

  task automatic test_x0();
    do_reset();
    set_hazard();
    ex_rd  = 5'd0;
    id_rs1 = 5'd0;
    #1;
    total++;
    if (outs !== O_NONE) begin
      bad++;
      $display("FAIL x0_outs got=%b exp=%b", outs, O_NONE);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL x0_stall_cnt got=%0d exp=0", stall_cnt);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    set_hazard();
    ex_redirect = 1'b1;
    imem_ready  = 1'b0;
    #1;
    total++;
    if (outs !== O_RDIR) begin
      bad++;
      $display("FAIL rd_outs got=%b exp=%b", outs, O_RDIR);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL rd_cnt got=%0d/%0d exp=1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_dmem_wait();
    do_reset();
    mem_access = 1'b1;
    dmem_ready = 1'b1;
    #1;
    total++;
    if (outs !== O_REQ) begin
      bad++;
      $display("FAIL dm_zero_wait got=%b exp=%b", outs, O_REQ);
    end
    dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs !== O_MSTL) begin
        bad++;
        $display("FAIL dm_wait%0d got=%b exp=%b", i, outs, O_MSTL);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    total++;
    if (outs !== O_REQ) begin
      bad++;
      $display("FAIL dm_release got=%b exp=%b", outs, O_REQ);
    end
    tick();
    clear_inputs();
    #1;
    total++;
    if (outs !== O_NONE || stall_cnt !== 4'd3) begin
      bad++;
      $display("FAIL dm_after got=%b/%0d exp=%b/3", outs, stall_cnt, O_NONE);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_hazard();
    ex_redirect = 1'b1;
    mem_access  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      total++;
      if (outs !== O_MSTL) begin
        bad++;
        $display("FAIL b2b_suppress%0d got=%b exp=%b", i, outs, O_MSTL);
      end
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    total++;
    if (outs !== O_RDREQ) begin
      bad++;
      $display("FAIL b2b_release got=%b exp=%b", outs, O_RDREQ);
    end
    tick();
    clear_inputs();
    ex_redirect = 1'b1;
    tick();
    tick();
    clear_inputs();
    #1;
    total++;
    if (flush_cnt !== 4'd3 || stall_cnt !== 4'd2) begin
      bad++;
      $display("FAIL b2b_cnt got=%0d/%0d exp=3/2", flush_cnt, stall_cnt);
    end
    set_hazard();
    tick();
    clear_inputs();
    imem_ready = 1'b0;
    #1;
    total++;
    if (outs !== O_IMEM) begin
      bad++;
      $display("FAIL b2b_imem got=%b exp=%b", outs, O_IMEM);
    end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    mem_access = 1'b1;
    tick();
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++;
      if (outs !== O_MSTL) begin
        bad++;
        $display("FAIL to_wait%0d got=%b exp=%b", i, outs, O_MSTL);
      end
      tick();
    end
    dmem_ready = 1'b1;
    mem_access = 1'b0;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if (outs !== O_FAULT) begin
        bad++;
        $display("FAIL to_fault%0d got=%b exp=%b", i, outs, O_FAULT);
      end
      tick();
    end
    total++;
    if (flush_cnt !== 4'd0) begin
      bad++;
      $display("FAIL to_flush_cnt got=%0d exp=0", flush_cnt);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    total++;
    if (outs !== O_NONE || stall_cnt !== 4'd0) begin
      bad++;
      $display("FAIL to_clear got=%b/%0d exp=%b/0", outs, stall_cnt, O_NONE);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    imem_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      #1;
      total++;
      if (outs !== O_IMEM) begin
        bad++;
        $display("FAIL sat_cycle%0d got=%b exp=%b", i, outs, O_IMEM);
      end
      tick();
    end
    clear_inputs();
    #1;
    total++;
    if (stall_cnt !== 4'd15) begin
      bad++;
      $display("FAIL sat_cnt got=%0d exp=15", stall_cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_x0();
    test_redirect();
    test_dmem_wait();
    test_back_to_back();
    test_timeout();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
